// File: rtl/csync_vsync_sep_pkg.sv
// Shared state encoding, boolean constants and the us-to-clocks conversion
// used by the csync_vsync_sep sync separator.
`ifndef CSYNC_VSYNC_SEP_PKG_SV
`define CSYNC_VSYNC_SEP_PKG_SV

`define CSV_US_TO_CLK(freq, us) ((((freq) / 1000) * (us)) / 1000)

package csync_vsync_sep_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LINE   = 2'd1,
    VCAND  = 2'd2,
    VSYNC  = 2'd3
  } sep_state_t;

endpackage

`endif

// File: rtl/csync_vsync_sep_pulse_width_meter.sv
// Synchroniser, optional 3-tap majority glitch filter (GLITCH_FILTER_EN),
// edge detection and low-pulse width counter for the sync separator.
module pulse_width_meter
  import csync_vsync_sep_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             csync_in,
  output logic             csync_s,
  output logic             rise_evt,
  output logic             edge_evt,
  output logic [CNT_W-1:0] width
);

  logic sync_meta;
  logic sync_q;
  logic csync_f;
  logic csync_d;
  logic fall_evt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_meta <= TRUE;
      sync_q    <= TRUE;
    end else begin
      sync_meta <= csync_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef GLITCH_FILTER_EN
  logic hist1;
  logic hist2;
  logic filt_q;

  // Registered majority of three consecutive samples: an edge moves two clocks later.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist1  <= TRUE;
      hist2  <= TRUE;
      filt_q <= TRUE;
    end else begin
      hist1  <= sync_q;
      hist2  <= hist1;
      filt_q <= (sync_q & hist1) | (sync_q & hist2) | (hist1 & hist2);
    end
  end

  assign csync_f = filt_q;
`else
  assign csync_f = sync_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      csync_d <= TRUE;
    end else begin
      csync_d <= csync_f;
    end
  end

  assign rise_evt = csync_f & ~csync_d;
  assign fall_evt = ~csync_f & csync_d;
  assign edge_evt = csync_f ^ csync_d;
  assign csync_s  = csync_f;

  // The falling-edge cycle counts as the first low cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      width <= '0;
    end else if (fall_evt) begin
      width <= CNT_W'(1);
    end else if (!csync_f && (width != '1)) begin
      width <= width + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csync_vsync_sep.sv
// Composite sync separator: classifies CSYNC low pulses as short or broad and
// derives active-low VSYNC plus a signal-present flag. Filter: GLITCH_FILTER_EN.
//   state  | meaning
//   SEARCH | no valid sync, waiting for a short pulse
//   LINE   | locked on line sync
//   VCAND  | counting consecutive broad pulses
//   VSYNC  | vertical interval, vsync_out low
module csync_vsync_sep
  import csync_vsync_sep_pkg::*;
#(
  parameter int CLK_FREQ     = 250_000,
  parameter int BROAD_MIN_US = 16,
  parameter int BROAD_N      = 3,
  parameter int TIMEOUT_US   = 200,
  parameter int CNT_W        = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic csync_in,
  output logic csync_out,
  output logic vsync_out,
  output logic signal_ok_out
);

  localparam int BROAD_MIN_CLK = `CSV_US_TO_CLK(CLK_FREQ, BROAD_MIN_US);
  localparam int TIMEOUT_CLK   = `CSV_US_TO_CLK(CLK_FREQ, TIMEOUT_US);
  localparam int BCNT_W        = $clog2(BROAD_N + 1);

  localparam logic [CNT_W-1:0]  BROAD_MIN_W = CNT_W'(BROAD_MIN_CLK);
  localparam logic [CNT_W-1:0]  TOUT_LAST   = CNT_W'(TIMEOUT_CLK - 1);
  localparam logic [BCNT_W-1:0] BROAD_N_W   = BCNT_W'(BROAD_N);

  sep_state_t        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              vsync_q, vsync_d;
  logic              ok_q, ok_d;
  logic [CNT_W-1:0]  tout_q;
  logic [CNT_W-1:0]  width;
  logic              csync_s;
  logic              rise_evt;
  logic              edge_evt;
  logic              is_broad;
  logic              is_short;
  logic              tout_hit;

  pulse_width_meter #(.CNT_W(CNT_W)) u_meter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .csync_in (csync_in),
    .csync_s  (csync_s),
    .rise_evt (rise_evt),
    .edge_evt (edge_evt),
    .width    (width)
  );

  assign is_broad = rise_evt && (width >= BROAD_MIN_W);
  assign is_short = rise_evt && (width < BROAD_MIN_W);
  // An edge clears the timer, so it always beats a simultaneous timeout.
  assign tout_hit = !edge_evt && (tout_q >= TOUT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tout_q <= '0;
    end else if (edge_evt) begin
      tout_q <= '0;
    end else if (tout_q != '1) begin
      tout_q <= tout_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= SEARCH;
      bcnt_q  <= '0;
      vsync_q <= TRUE;
      ok_q    <= FALSE;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      vsync_q <= vsync_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    vsync_d = vsync_q;
    ok_d    = ok_q;
    if (tout_hit) begin
      state_d = SEARCH;
      bcnt_d  = '0;
      vsync_d = TRUE;
      ok_d    = FALSE;
    end else begin
      case (state_q)
        SEARCH: begin
          if (is_short) begin
            state_d = LINE;
            ok_d    = TRUE;
          end
        end
        LINE: begin
          if (is_broad) begin
            if (BROAD_N == 1) begin
              state_d = VSYNC;
              bcnt_d  = BROAD_N_W;
              vsync_d = FALSE;
            end else begin
              state_d = VCAND;
              bcnt_d  = BCNT_W'(1);
            end
          end
        end
        VCAND: begin
          if (is_broad) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            if ((bcnt_q + BCNT_W'(1)) == BROAD_N_W) begin
              state_d = VSYNC;
              vsync_d = FALSE;
            end
          end else if (is_short) begin
            state_d = LINE;
            bcnt_d  = '0;
          end
        end
        VSYNC: begin
          if (is_short) begin
            state_d = LINE;
            bcnt_d  = '0;
            vsync_d = TRUE;
          end
        end
        default: begin
          state_d = SEARCH;
          bcnt_d  = '0;
          vsync_d = TRUE;
          ok_d    = FALSE;
        end
      endcase
    end
  end

  assign csync_out     = csync_s;
  assign vsync_out     = vsync_q;
  assign signal_ok_out = ok_q;

endmodule
